layer_engine: RTL and testbench



---
 rtl/layer_engine.sv | 179 +++++++++++++++++
 tb/tb_layer_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_engine.sv
`default_nettype none
// ============================================================================
// layer_engine : sequential multi-lane MAC engine for one fully-connected layer
// Optional feature: define LAYER_ENGINE_RELU_EN to clamp negative results to 0
// Revision: 1.0
// ============================================================================
module layer_engine #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int WEIGHT_WIDTH = 8,
  parameter  int MAC_NUM      = 8,
  parameter  int IN_LEN       = 4,
  parameter  int OUT_NUM      = 8,
  localparam int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + $clog2(MAC_NUM * IN_LEN) + 1,
  localparam int K_W          = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int N_W          = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1,
  localparam int WA_W         = (IN_LEN * OUT_NUM > 1) ? $clog2(IN_LEN * OUT_NUM) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  output logic [K_W-1:0]                      x_addr_o,
  output logic                                x_en_o,
  input  logic [MAC_NUM*DATA_WIDTH-1:0]       x_data_i,
  output logic [WA_W-1:0]                     w_addr_o,
  output logic                                w_en_o,
  input  logic [MAC_NUM*WEIGHT_WIDTH-1:0]     w_data_i,
  output logic signed [ACC_WIDTH-1:0]         out_o,
  output logic [N_W-1:0]                      out_idx_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [K_W-1:0] K_LAST = K_W'(IN_LEN - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(OUT_NUM - 1);

  logic [2:0]                  state_q, state_d;
  logic [K_W-1:0]              k_q, k_d;
  logic [N_W-1:0]              n_q, n_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        rd_valid_q, rd_valid_d;

  logic signed [PROD_W-1:0]    prod [MAC_NUM];
  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0] result;

  genvar l;
  generate
    for (l = 0; l < MAC_NUM; l++) begin : g_lane
      logic signed [DATA_WIDTH-1:0]   x_l;
      logic signed [WEIGHT_WIDTH-1:0] w_l;
      assign x_l     = x_data_i[l*DATA_WIDTH +: DATA_WIDTH];
      assign w_l     = w_data_i[l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign prod[l] = PROD_W'(x_l) * PROD_W'(w_l);
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      lane_sum = lane_sum + ACC_WIDTH'(prod[i]);
    end
  end

`ifdef LAYER_ENGINE_RELU_EN
  assign result = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
`else
  assign result = acc_q;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (k_q == K_LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   if (out_ready_i) state_d = (n_q == N_LAST) ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory data arrives the cycle after a read, so accumulation is qualified
  // by a delayed copy of the RUN state rather than by the state itself.
  always_comb begin
    k_d        = k_q;
    n_d        = n_q;
    acc_d      = acc_q;
    rd_valid_d = (state_q == S_RUN);
    if (rd_valid_q) begin
      acc_d = acc_q + lane_sum;
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d   = '0;
          n_d   = '0;
          acc_d = '0;
        end
      end
      S_RUN: begin
        k_d = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
      end
      S_OUT: begin
        if (out_ready_i && (n_q != N_LAST)) begin
          n_d   = n_q + N_W'(1);
          k_d   = '0;
          acc_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Output logic
  always_comb begin
    x_en_o      = 1'b0;
    w_en_o      = 1'b0;
    x_addr_o    = '0;
    w_addr_o    = '0;
    out_valid_o = 1'b0;
    out_o       = '0;
    out_idx_o   = '0;
    done_o      = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_RUN: begin
        x_en_o   = 1'b1;
        w_en_o   = 1'b1;
        x_addr_o = k_q;
        w_addr_o = WA_W'(n_q) * WA_W'(IN_LEN) + WA_W'(k_q);
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        out_o       = result;
        out_idx_o   = n_q;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_engine.sv
`default_nettype none
// tb_layer_engine : randomized scoreboard bench for layer_engine with
// behavioural memories and a dot-product reference model.
module tb_layer_engine;

  localparam int DW  = 8;
  localparam int WW  = 8;
  localparam int MN  = 8;
  localparam int IL  = 4;
  localparam int ON  = 8;
  localparam int AW  = DW + WW + $clog2(MN * IL) + 1;
  localparam int KW  = (IL > 1) ? $clog2(IL) : 1;
  localparam int NW  = (ON > 1) ? $clog2(ON) : 1;
  localparam int WAW = (IL * ON > 1) ? $clog2(IL * ON) : 1;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic [KW-1:0]        x_addr_o;
  logic                 x_en_o;
  logic [MN*DW-1:0]     x_data_i;
  logic [WAW-1:0]       w_addr_o;
  logic                 w_en_o;
  logic [MN*WW-1:0]     w_data_i;
  logic signed [AW-1:0] out_o;
  logic [NW-1:0]        out_idx_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 busy_o;
  logic                 done_o;

  always #5 clk = ~clk;

  layer_engine #(
    .DATA_WIDTH  (DW),
    .WEIGHT_WIDTH(WW),
    .MAC_NUM     (MN),
    .IN_LEN      (IL),
    .OUT_NUM     (ON)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .x_addr_o   (x_addr_o),
    .x_en_o     (x_en_o),
    .x_data_i   (x_data_i),
    .w_addr_o   (w_addr_o),
    .w_en_o     (w_en_o),
    .w_data_i   (w_data_i),
    .out_o      (out_o),
    .out_idx_o  (out_idx_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct {
    int     idx;
    longint val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 1'b0;
  bit   hold_q = 1'b0;
  bit   done_pend = 1'b0;
  longint hold_out;
  longint hold_idx;

  logic [MN*DW-1:0] x_mem [IL];
  logic [MN*WW-1:0] w_mem [IL*ON];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_val(input int width);
    case ($urandom_range(0, 3))
      0:       return -(1 << (width - 1));
      1:       return (1 << (width - 1)) - 1;
      default: return int'($urandom_range(0, (1 << width) - 1)) - (1 << (width - 1));
    endcase
  endfunction

  // Synchronous-read memories; idle cycles return garbage so that any
  // accumulation of unrequested data shows up in the results.
  always @(posedge clk) begin
    logic [MN*DW-1:0] rx;
    logic [MN*WW-1:0] rw;
    for (int l = 0; l < MN; l++) begin
      rx[l*DW +: DW] = DW'($urandom);
      rw[l*WW +: WW] = WW'($urandom);
    end
    x_data_i <= x_en_o ? x_mem[x_addr_o] : rx;
    w_data_i <= w_en_o ? w_mem[w_addr_o] : rw;
  end

  always @(posedge clk) begin
    #2;
    if (rnd_ready) out_ready_i = 1'($urandom_range(0, 1));
  end

  // mode 0: all ones, 1: all most-negative, 2: x=1 w=-1, 3: random
  task automatic fill(input int mode);
    int xv, wv;
    for (int k = 0; k < IL; k++)
      for (int l = 0; l < MN; l++) begin
        case (mode)
          0: xv = 1;
          1: xv = -(1 << (DW - 1));
          2: xv = 1;
          default: xv = rnd_val(DW);
        endcase
        x_mem[k][l*DW +: DW] = DW'(xv);
      end
    for (int a = 0; a < IL * ON; a++)
      for (int l = 0; l < MN; l++) begin
        case (mode)
          0: wv = 1;
          1: wv = -(1 << (WW - 1));
          2: wv = -1;
          default: wv = rnd_val(WW);
        endcase
        w_mem[a][l*WW +: WW] = WW'(wv);
      end
  endtask

  function automatic longint model(input int n);
    longint s = 0;
    logic signed [DW-1:0] a;
    logic signed [WW-1:0] b;
    for (int k = 0; k < IL; k++)
      for (int l = 0; l < MN; l++) begin
        a = x_mem[k][l*DW +: DW];
        b = w_mem[n*IL + k][l*WW +: WW];
        s += longint'(a) * longint'(b);
      end
`ifdef LAYER_ENGINE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic push_run();
    exp_t e;
    for (int n = 0; n < ON; n++) begin
      e.idx = n;
      e.val = model(n);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done_o && c < 2000) begin
      tick();
      c++;
    end
    chk("done_seen", longint'(done_o), 1);
  endtask

  task automatic run();
    push_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done();
    tick();
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (!x_en_o) chk("x_addr_idle", longint'(x_addr_o), 0);
      if (!w_en_o) chk("w_addr_idle", longint'(w_addr_o), 0);
      chk("en_pair", longint'(x_en_o), longint'(w_en_o));
      if (out_valid_o) chk("no_read_in_out", longint'(x_en_o), 0);
      if (hold_q) begin
        chk("hold_valid", longint'(out_valid_o), 1);
        chk("hold_out", longint'(out_o), hold_out);
        chk("hold_idx", longint'(out_idx_o), hold_idx);
      end
      hold_q   = out_valid_o && !out_ready_i;
      hold_out = longint'(out_o);
      hold_idx = longint'(out_idx_o);
      chk("done_pulse", longint'(done_o), longint'(done_pend));
      done_pend = 1'b0;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got idx %0d val %0d expected none", out_idx_o, out_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_idx", longint'(out_idx_o), e.idx);
          chk("out_val", longint'(out_o), e.val);
          if (e.idx == ON - 1) done_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint sv_out;
    longint sv_idx;
    int c;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    out_ready_i = 1'b0;
    fill(0);
    repeat (3) tick();
    chk("rst_busy",  longint'(busy_o), 0);
    chk("rst_done",  longint'(done_o), 0);
    chk("rst_valid", longint'(out_valid_o), 0);
    chk("rst_x_en",  longint'(x_en_o), 0);
    chk("rst_w_en",  longint'(w_en_o), 0);
    chk("rst_out",   longint'(out_o), 0);
    chk("rst_idx",   longint'(out_idx_o), 0);
    rst_i = 1'b0;

    // All-ones data with ready high, including first-result latency
    out_ready_i = 1'b1;
    push_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", longint'(busy_o), 1);
    repeat (IL) tick();
    chk("lat_early", longint'(out_valid_o), 0);
    tick();
    chk("lat_valid", longint'(out_valid_o), 1);
    wait_done();
    tick();
    chk("idle_after_done", longint'(busy_o), 0);

    fill(1);
    run();
    fill(2);
    run();

    // Downstream stall for five cycles on the first result
    fill(3);
    out_ready_i = 1'b0;
    push_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    c = 0;
    while (!out_valid_o && c < 100) begin
      tick();
      c++;
    end
    chk("stall_valid", longint'(out_valid_o), 1);
    sv_out = longint'(out_o);
    sv_idx = longint'(out_idx_o);
    repeat (5) begin
      tick();
      chk("stall_hold_valid", longint'(out_valid_o), 1);
      chk("stall_hold_out", longint'(out_o), sv_out);
      chk("stall_hold_idx", longint'(out_idx_o), sv_idx);
      chk("stall_no_read", longint'(x_en_o | w_en_o), 0);
    end
    out_ready_i = 1'b1;
    wait_done();
    tick();

    // Random data with random back-pressure
    for (int r = 0; r < 6; r++) begin
      fill(3);
      rnd_ready = 1'b1;
      run();
      rnd_ready = 1'b0;
      tick();
      out_ready_i = 1'b1;
    end

    // Reset while neuron 3 is being read
    fill(3);
    out_ready_i = 1'b1;
    push_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    c = 0;
    while (!(w_en_o && int'(w_addr_o) >= 3 * IL) && c < 500) begin
      tick();
      c++;
    end
    chk("reach_neuron3", longint'(w_en_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    hold_q    = 1'b0;
    done_pend = 1'b0;
    chk("abort_busy",  longint'(busy_o), 0);
    chk("abort_valid", longint'(out_valid_o), 0);
    chk("abort_done",  longint'(done_o), 0);
    repeat (10) begin
      tick();
      chk("abort_quiet_done", longint'(done_o), 0);
      chk("abort_quiet_busy", longint'(busy_o), 0);
    end
    run();

    // start_i held high: one run, IDLE for one cycle, then a fresh run
    fill(3);
    push_run();
    push_run();
    start_i = 1'b1;
    wait_done();
    tick();
    chk("held_start_idle", longint'(busy_o), 0);
    tick();
    chk("held_start_restart", longint'(busy_o), 1);
    start_i = 1'b0;
    wait_done();
    repeat (3) tick();

    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
